// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the RV32 data-memory interface: load funct3 codes,
// store size codes and the request bus widths.
package rv32_mem_pkg;

  localparam int READ_W  = 4;
  localparam int WRITE_W = 3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/dmem.sv
// Byte-addressed little-endian data memory with fixed access latency, stalling
// the pipeline through busywait until the access completes.
//
// state | meaning
// IDLE  | waiting; a request raises busywait at once and is captured
// BUSY  | counting up to LATENCY; the access happens on the terminal edge
// ACK   | busywait low for one cycle, readdata valid, CPU advances
module dmem
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [READ_W-1:0]  read,
  input  logic [WRITE_W-1:0] write,
  input  logic [31:0]        address,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               busywait
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ACK
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   counter;
  logic [READ_W-1:0]  req_read;
  logic [WRITE_W-1:0] req_write;
  logic [AW-1:0]      req_idx;
  logic [31:0]        req_wdata;

  logic [7:0] mem [DEPTH_BYTES];

  logic        req_valid;
  logic        at_terminal;
  logic        do_write;
  logic        do_read;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_word;
  logic        unused_addr_bits;

  // Upper address bits only select an alias of the same storage.
  assign unused_addr_bits = ^address[31:AW];

  assign req_valid   = read[READ_W-1] | write[WRITE_W-1];
  assign at_terminal = (state == ST_BUSY) && (counter == CNT_W'(LATENCY));
  assign do_write    = at_terminal && req_write[WRITE_W-1];
  assign do_read     = at_terminal && req_read[READ_W-1] && !req_write[WRITE_W-1];

  assign ld_word = {mem[{req_idx[AW-1:2], 2'd3}], mem[{req_idx[AW-1:2], 2'd2}],
                    mem[{req_idx[AW-1:2], 2'd1}], mem[{req_idx[AW-1:2], 2'd0}]};

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LBU:  return {24'd0, b};
      F3_LHU:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Store data is replicated across lanes so the byte enables pick the target.
  always_comb begin
    st_be   = 4'b1111;
    st_data = req_wdata;
    case (req_write[1:0])
      SZ_B: begin
        st_be   = 4'b0001 << req_idx[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        st_be   = req_idx[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    busywait  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          busywait  = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busywait = 1'b1;
        if (counter == CNT_W'(LATENCY)) state_nxt = ST_ACK;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      counter   <= '0;
      readdata  <= '0;
      req_read  <= '0;
      req_write <= '0;
      req_idx   <= '0;
      req_wdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_read  <= read;
            req_write <= write;
            req_idx   <= address[AW-1:0];
            req_wdata <= writedata;
            counter   <= CNT_W'(1);
          end
        end
        ST_BUSY: begin
          if (!at_terminal) counter <= counter + CNT_W'(1);
        end
        default: ;
      endcase
      if (do_read) readdata <= load_extend(req_read[2:0], req_idx[1:0], ld_word);
    end
  end

  for (genvar g = 0; g < DEPTH_BYTES; g++) begin : g_byte
    always_ff @(posedge clock) begin
      if (reset) begin
        mem[g] <= '0;
      end else if (do_write && st_be[g % 4] && (req_idx[AW-1:2] == (AW-2)'(g / 4))) begin
        mem[g] <= st_data[8*(g % 4) +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem.sv
// Self-checking bench for dmem: directed scenarios then randomized loads and
// stores, compared against a byte-array reference model.
module tb_dmem;
  import rv32_mem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  read;
  logic [2:0]  write;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;

  always #5 clock = ~clock;

  dmem #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clock    (clock),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .address  (address),
    .writedata(writedata),
    .readdata (readdata),
    .busywait (busywait)
  );

  logic [7:0]  model [DEPTH];
  logic [31:0] last_rd;
  int          passed = 0;
  int          total  = 0;

  localparam logic [3:0] R_NONE = 4'b0000;
  localparam logic [3:0] R_LB   = 4'b1000;
  localparam logic [3:0] R_LH   = 4'b1001;
  localparam logic [3:0] R_LW   = 4'b1010;
  localparam logic [3:0] R_LBU  = 4'b1100;
  localparam logic [3:0] R_LHU  = 4'b1101;
  localparam logic [3:0] R_UND  = 4'b1011;
  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_SB   = 3'b100;
  localparam logic [2:0] W_SH   = 3'b101;
  localparam logic [2:0] W_SW   = 3'b110;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'd0;
    last_rd = 32'd0;
  endtask

  task automatic model_apply(input logic [3:0] rd, input logic [2:0] wr,
                             input logic [31:0] addr, input logic [31:0] wd);
    int idx, base, v;
    idx = int'(addr % DEPTH);
    if (wr[2]) begin
      if (wr[1:0] == 2'b00) begin
        model[idx] = wd[7:0];
      end else if (wr[1:0] == 2'b01) begin
        base = idx - idx % 2;
        model[base]     = wd[7:0];
        model[base + 1] = wd[15:8];
      end else begin
        base = idx - idx % 4;
        for (int k = 0; k < 4; k++) model[base + k] = wd[8*k +: 8];
      end
    end else if (rd[3]) begin
      case (rd[2:0])
        3'd0: begin
          v = int'(model[idx]);
          if (v >= 128) v -= 256;
          last_rd = 32'(v);
        end
        3'd1: begin
          base = idx - idx % 2;
          v = int'(model[base]) + 256 * int'(model[base + 1]);
          if (v >= 32768) v -= 65536;
          last_rd = 32'(v);
        end
        3'd4: last_rd = 32'(int'(model[idx]));
        3'd5: begin
          base = idx - idx % 2;
          last_rd = 32'(int'(model[base]) + 256 * int'(model[base + 1]));
        end
        default: begin
          base = idx - idx % 4;
          last_rd = {model[base + 3], model[base + 2], model[base + 1], model[base]};
        end
      endcase
    end
  endtask

  // One complete request: busy-cycle count, result, then quiet IDLE afterwards.
  task automatic do_op(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n;
    @(posedge clock); #1;
    read = rd; write = wr; address = addr; writedata = wd;
    #1;
    n = 0;
    while (busywait && n < 20) begin
      n++;
      @(posedge clock); #1;
      if (n == 1) begin
        read = 4'($urandom); write = 3'($urandom);
        address = $urandom; writedata = $urandom;
        #1;
      end
    end
    check({tag, " busy_cycles"}, 32'(n), 32'(LAT + 1));
    model_apply(rd, wr, addr, wd);
    check({tag, " readdata"}, readdata, last_rd);
    read = R_NONE; write = W_NONE;
    @(posedge clock); #1;
    check({tag, " idle_busywait"}, 32'(busywait), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr;
    int          op;

    reset = 1'b1; read = R_NONE; write = W_NONE; address = '0; writedata = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check("reset readdata", readdata, 32'd0);
    check("reset busywait", 32'(busywait), 32'd0);
    reset = 1'b0;

    do_op("lw_10", R_LW, W_NONE, 32'h10, '0);
    check("lw_10 const", readdata, 32'h0000_0000);
    do_op("sw_20", R_NONE, W_SW, 32'h20, 32'hDEAD_BEEF);
    do_op("lw_20", R_LW, W_NONE, 32'h20, '0);
    check("lw_20 const", readdata, 32'hDEAD_BEEF);
    do_op("sb_41", R_NONE, W_SB, 32'h41, 32'h0000_0080);
    do_op("lb_41", R_LB, W_NONE, 32'h41, '0);
    check("lb_41 const", readdata, 32'hFFFF_FF80);
    do_op("lbu_41", R_LBU, W_NONE, 32'h41, '0);
    check("lbu_41 const", readdata, 32'h0000_0080);
    do_op("lw_40", R_LW, W_NONE, 32'h40, '0);
    check("lw_40 const", readdata, 32'h0000_8000);
    do_op("sh_52", R_NONE, W_SH, 32'h52, 32'h0000_1234);
    do_op("lh_53", R_LH, W_NONE, 32'h53, '0);
    check("lh_53 const", readdata, 32'h0000_1234);
    do_op("sh_52b", R_NONE, W_SH, 32'h52, 32'h0000_F00D);
    do_op("lhu_52", R_LHU, W_NONE, 32'h52, '0);
    check("lhu_52 const", readdata, 32'h0000_F00D);
    do_op("lh_52neg", R_LH, W_NONE, 32'h52, '0);
    check("lh_52neg const", readdata, 32'hFFFF_F00D);
    do_op("sw_400", R_NONE, W_SW, 32'h400, 32'hCAFE_BABE);
    do_op("lw_000", R_LW, W_NONE, 32'h000, '0);
    check("lw_000 const", readdata, 32'hCAFE_BABE);
    do_op("both_80", R_LW, W_SW, 32'h80, 32'h1357_9BDF);
    check("both_80 held", readdata, 32'hCAFE_BABE);
    do_op("und_81", R_UND, W_NONE, 32'h81, '0);
    check("und_81 const", readdata, 32'h1357_9BDF);
    do_op("sz11_90", R_NONE, 3'b111, 32'h91, 32'hA5A5_5A5A);
    do_op("lw_90", R_LW, W_NONE, 32'h90, '0);
    check("lw_90 const", readdata, 32'hA5A5_5A5A);

    for (int i = 0; i < 200; i++) begin
      op   = int'($urandom_range(0, 9));
      rd   = {1'b1, 3'($urandom)};
      wr   = {1'b1, 2'($urandom)};
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_FC00);
      if (op < 4)      wr = W_NONE;
      else if (op < 8) rd = R_NONE;
      do_op("rand", rd, wr, addr, $urandom);
    end

    @(posedge clock); #1;
    read = R_NONE; write = W_SW; address = 32'h60; writedata = 32'h1111_1111;
    @(posedge clock); #1;
    reset = 1'b1; write = W_NONE;
    @(posedge clock); #1;
    check("midreset busywait", 32'(busywait), 32'd0);
    check("midreset readdata", readdata, 32'd0);
    reset = 1'b0;
    model_clear();
    do_op("lw_60", R_LW, W_NONE, 32'h60, '0);
    check("lw_60 const", readdata, 32'h0000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
